ard_bus_bridge: RTL and testbench

ARD_BUS_BRIDGE -- requirements
Module: ard_bus_bridge

---
 rtl/ard_bus_bridge.sv | 190 +++++++++++++++++++
 tb/tb_ard_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ard_bus_bridge.sv
// Bus bridge between a CPU word interface and a narrow Arduino strobe/ack bus.
// Words are serialised least-significant beat first over a 4-phase handshake.
module ard_bus_bridge #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned BEATS  = WORD_W / BUS_W,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic [CH_W-1:0]   tx_ch,
  input  logic              rx_req,
  input  logic [CH_W-1:0]   rx_ch,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              err,
  output logic [BUS_W-1:0]  out_bus,
  output logic              out_strobe,
  output logic [NUM_CH-1:0] ch_sel,
  input  logic              ard_receive_ready,
  input  logic [BUS_W-1:0]  in_bus,
  input  logic              ard_data_ready,
  output logic              in_ack
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [SW-1:0]   STALL_MAX = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CH_W:0]   CH_LIMIT  = (CH_W + 1)'(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE  = NUM_CH'(1);

  typedef enum logic [2:0] {
    IDLE,
    TX_DRIVE,
    TX_RELEASE,
    RX_WAIT,
    RX_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WORD_W-1:0] tx_word_q, tx_word_d;
  logic [WORD_W-1:0] rx_buf_q, rx_buf_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              err_q, err_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic              ready_en_q;
  logic              rr_meta_q, rr_sync_q;
  logic              dr_meta_q, dr_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      ch_q       <= '0;
      tx_word_q  <= '0;
      rx_buf_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      ready_en_q <= 1'b0;
      rr_meta_q  <= 1'b0;
      rr_sync_q  <= 1'b0;
      dr_meta_q  <= 1'b0;
      dr_sync_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      ch_q       <= ch_d;
      tx_word_q  <= tx_word_d;
      rx_buf_q   <= rx_buf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      ready_en_q <= 1'b1;
      rr_meta_q  <= ard_receive_ready;
      rr_sync_q  <= rr_meta_q;
      dr_meta_q  <= ard_data_ready;
      dr_sync_q  <= dr_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    ch_d       = ch_q;
    tx_word_d  = tx_word_q;
    rx_buf_d   = rx_buf_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = err_q;
    stall_d    = '0;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        // Write has priority; a held rx_req is picked up once we are back here.
        if (tx_valid && tx_ready) begin
          if ({1'b0, tx_ch} >= CH_LIMIT) begin
            err_d = 1'b1;
          end else begin
            tx_word_d = tx_data;
            ch_d      = tx_ch;
            err_d     = 1'b0;
            state_d   = TX_DRIVE;
          end
        end else if (rx_req && ready_en_q) begin
          if ({1'b0, rx_ch} >= CH_LIMIT) begin
            err_d = 1'b1;
          end else begin
            ch_d    = rx_ch;
            err_d   = 1'b0;
            state_d = RX_WAIT;
          end
        end
      end
      TX_DRIVE: begin
        if (rr_sync_q) state_d = TX_RELEASE;
      end
      TX_RELEASE: begin
        if (!rr_sync_q) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = TX_DRIVE;
          end
        end
      end
      RX_WAIT: begin
        if (dr_sync_q) begin
          rx_buf_d[beat_q*BUS_W +: BUS_W] = in_bus;
          state_d = RX_RELEASE;
        end
      end
      RX_RELEASE: begin
        if (!dr_sync_q) begin
          if (beat_q == LAST_BEAT) begin
            rx_data_d  = rx_buf_q;
            rx_valid_d = 1'b1;
            beat_d     = '0;
            state_d    = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = RX_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Any state change is progress; only a full stall window aborts.
    if (state_q != IDLE && state_d == state_q) begin
      if (TIMEOUT != 0 && stall_q == STALL_MAX) begin
        state_d = IDLE;
        beat_d  = '0;
        err_d   = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_ready   = (state_q == IDLE) && ready_en_q;
    out_strobe = (state_q == TX_DRIVE);
    in_ack     = (state_q == RX_RELEASE);
    out_bus    = '0;
    if (state_q == TX_DRIVE || state_q == TX_RELEASE)
      out_bus = tx_word_q[beat_q*BUS_W +: BUS_W];
    ch_sel = '0;
    if (state_q != IDLE)
      ch_sel = CH_ONE << ch_q;
    rx_valid = rx_valid_q;
    rx_data  = rx_data_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_ard_bus_bridge.sv
// Directed bench for ard_bus_bridge: write/read handshakes, arbitration,
// timeout, invalid channel and mid-transfer reset.
module tb_ard_bus_bridge;

  localparam int LIM = 20;

  logic        clk;
  logic        rst_n;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_ch;
  logic        rx_req;
  logic [1:0]  rx_ch;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        err;
  logic [7:0]  out_bus;
  logic        out_strobe;
  logic [2:0]  ch_sel;
  logic        ard_receive_ready;
  logic [7:0]  in_bus;
  logic        ard_data_ready;
  logic        in_ack;

  int checks;
  int errors;
  int cyc;
  int multi_sel;
  int rx_pulses;
  int t0;

  ard_bus_bridge #(
    .WORD_W (16),
    .BUS_W  (8),
    .NUM_CH (3),
    .TIMEOUT(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_ch            (tx_ch),
    .rx_req           (rx_req),
    .rx_ch            (rx_ch),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .err              (err),
    .out_bus          (out_bus),
    .out_strobe       (out_strobe),
    .ch_sel           (ch_sel),
    .ard_receive_ready(ard_receive_ready),
    .in_bus           (in_bus),
    .ard_data_ready   (ard_data_ready),
    .in_ack           (in_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    multi_sel = 0;
    rx_pulses = 0;
  end
  always @(negedge clk) begin
    if ($countones(ch_sel) > 1) multi_sel <= multi_sel + 1;
    if (rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return out_strobe;
      1: return tx_ready;
      2: return in_ack;
      default: return rx_valid;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input logic val);
    int n;
    n = 0;
    while (probe(sel) !== val && n < LIM) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, probe(sel)}, {31'd0, val});
  endtask

  task automatic do_tx(input logic [15:0] word, input logic [2:0] chs);
    for (int b = 0; b < 2; b++) begin
      wait_until("tx_strobe_rise", 0, 1'b1);
      chk("tx_beat", {24'd0, out_bus}, {24'd0, word[b*8 +: 8]});
      chk("tx_ch_sel", {29'd0, ch_sel}, {29'd0, chs});
      chk("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
      ard_receive_ready = 1'b1;
      wait_until("tx_strobe_fall", 0, 1'b0);
      chk("tx_beat_held", {24'd0, out_bus}, {24'd0, word[b*8 +: 8]});
      chk("tx_ch_sel_rel", {29'd0, ch_sel}, {29'd0, chs});
      ard_receive_ready = 1'b0;
    end
    wait_until("tx_done", 1, 1'b1);
    chk("tx_idle_ch_sel", {29'd0, ch_sel}, 32'd0);
    chk("tx_idle_bus", {24'd0, out_bus}, 32'd0);
  endtask

  task automatic do_rx(input logic [7:0] b0, input logic [7:0] b1, input logic [2:0] chs,
                       input logic [15:0] prev, input logic [15:0] word);
    in_bus = b0;
    ard_data_ready = 1'b1;
    wait_until("rx_ack1_rise", 2, 1'b1);
    chk("rx_ch_sel", {29'd0, ch_sel}, {29'd0, chs});
    ard_data_ready = 1'b0;
    wait_until("rx_ack1_fall", 2, 1'b0);
    chk("rx_partial_hold", {16'd0, rx_data}, {16'd0, prev});
    chk("rx_no_early_valid", {31'd0, rx_valid}, 32'd0);
    in_bus = b1;
    ard_data_ready = 1'b1;
    wait_until("rx_ack2_rise", 2, 1'b1);
    chk("rx_partial_hold2", {16'd0, rx_data}, {16'd0, prev});
    ard_data_ready = 1'b0;
    wait_until("rx_valid_pulse", 3, 1'b1);
    chk("rx_word", {16'd0, rx_data}, {16'd0, word});
    chk("rx_ack_low", {31'd0, in_ack}, 32'd0);
    chk("rx_idle_ch_sel", {29'd0, ch_sel}, 32'd0);
    tick();
    chk("rx_valid_one_cycle", {31'd0, rx_valid}, 32'd0);
    chk("rx_word_held", {16'd0, rx_data}, {16'd0, word});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    tx_ch = '0;
    rx_req = 1'b0;
    rx_ch = '0;
    ard_receive_ready = 1'b0;
    in_bus = '0;
    ard_data_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_strobe", {31'd0, out_strobe}, 32'd0);
    chk("rst_bus", {24'd0, out_bus}, 32'd0);
    chk("rst_ch_sel", {29'd0, ch_sel}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Write 0xBEEF to MAR
    tx_valid = 1'b1;
    tx_data = 16'hBEEF;
    tx_ch = 2'd1;
    tick();
    t0 = cyc;
    tx_valid = 1'b0;
    do_tx(16'hBEEF, 3'b010);
    chk("tx_latency", cyc - t0, 32'd12);
    chk("tx_err_clear", {31'd0, err}, 32'd0);

    // Read 0x1234 from MDR
    rx_req = 1'b1;
    rx_ch = 2'd2;
    tick();
    rx_req = 1'b0;
    do_rx(8'h34, 8'h12, 3'b100, 16'h0000, 16'h1234);

    // Simultaneous write and read: write first
    tx_valid = 1'b1;
    tx_data = 16'hA55A;
    tx_ch = 2'd0;
    rx_req = 1'b1;
    rx_ch = 2'd1;
    tick();
    tx_valid = 1'b0;
    chk("arb_tx_first", {29'd0, ch_sel}, 32'd1);
    do_tx(16'hA55A, 3'b001);
    tick();
    chk("arb_rx_after", {29'd0, ch_sel}, 32'd2);
    rx_req = 1'b0;
    do_rx(8'h78, 8'h56, 3'b010, 16'h1234, 16'h5678);

    // Timeout with no ack
    tx_valid = 1'b1;
    tx_data = 16'hDEAD;
    tx_ch = 2'd0;
    tick();
    tx_valid = 1'b0;
    chk("to_driving", {31'd0, out_strobe}, 32'd1);
    repeat (15) tick();
    chk("to_still_driving", {31'd0, out_strobe}, 32'd1);
    chk("to_err_not_yet", {31'd0, err}, 32'd0);
    tick();
    chk("to_strobe_drop", {31'd0, out_strobe}, 32'd0);
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("to_bus_drop", {24'd0, out_bus}, 32'd0);
    tx_valid = 1'b1;
    tx_data = 16'h0102;
    tx_ch = 2'd2;
    tick();
    tx_valid = 1'b0;
    chk("to_err_cleared", {31'd0, err}, 32'd0);
    do_tx(16'h0102, 3'b100);

    // Invalid channel
    tx_valid = 1'b1;
    tx_data = 16'hFFFF;
    tx_ch = 2'd3;
    tick();
    tx_valid = 1'b0;
    chk("bad_ch_strobe", {31'd0, out_strobe}, 32'd0);
    chk("bad_ch_err", {31'd0, err}, 32'd1);
    chk("bad_ch_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("bad_ch_sel", {29'd0, ch_sel}, 32'd0);
    tick();
    chk("bad_ch_strobe2", {31'd0, out_strobe}, 32'd0);

    // Reset during second read beat
    rx_req = 1'b1;
    rx_ch = 2'd2;
    tick();
    rx_req = 1'b0;
    chk("rx_err_cleared", {31'd0, err}, 32'd0);
    in_bus = 8'hAA;
    ard_data_ready = 1'b1;
    wait_until("mr_ack1_rise", 2, 1'b1);
    ard_data_ready = 1'b0;
    wait_until("mr_ack1_fall", 2, 1'b0);
    in_bus = 8'hBB;
    ard_data_ready = 1'b1;
    wait_until("mr_ack2_rise", 2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_in_ack", {31'd0, in_ack}, 32'd0);
    chk("mr_ch_sel", {29'd0, ch_sel}, 32'd0);
    chk("mr_rx_data", {16'd0, rx_data}, 32'd0);
    chk("mr_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mr_strobe", {31'd0, out_strobe}, 32'd0);
    ard_data_ready = 1'b0;
    in_bus = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mr_rx_data_after", {16'd0, rx_data}, 32'd0);
    chk("mr_tx_ready", {31'd0, tx_ready}, 32'd1);

    chk("never_two_channels", multi_sel, 32'd0);
    chk("rx_valid_pulses", rx_pulses, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
